// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multi-port integer register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register file: read ports, two retire lanes, clear handshake.
interface reg_file_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                 init_req;
    logic                 ready;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;
    logic                 we0;
    logic [AW-1:0]        wa0;
    logic [XLEN-1:0]      wd0;
    logic                 we1;
    logic [AW-1:0]        wa1;
    logic [XLEN-1:0]      wd1;

    modport master (
        output init_req, ra, we0, wa0, wd0, we1, wa1, wd1,
        input  ready, rd
    );

    modport slave (
        input  init_req, ra, we0, wa0, wd0, we1, wa1, wd1,
        output ready, rd
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: storage mux with zero-entry override and lane-1-first write bypass.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            active,
    input  logic            fwd_en,
    input  logic [AW-1:0]   ra,
    input  logic [XLEN-1:0] regs [NREGS],
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    output logic [XLEN-1:0] rd_c
);

    // Lane 1 is checked first so a same-address collision forwards the younger value.
    always_comb begin
        rd_c = regs[ra];
        if (!active) begin
            rd_c = '0;
        end else if ((ZERO_REG != 0) && (ra == '0)) begin
            rd_c = '0;
        end else if ((BYPASS != 0) && fwd_en && we1 && (wa1 == ra)) begin
            rd_c = wd1;
        end else if ((BYPASS != 0) && fwd_en && we0 && (wa0 == ra)) begin
            rd_c = wd0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two prioritised write lanes and a hardware clear sequencer.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = NRD_DEF,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_mp_if.slave   bus
);

    localparam int unsigned AW      = $clog2(NREGS);
    localparam logic [0:0]  S_CLEAR = 1'(CLEAR);
    localparam logic [0:0]  S_READY = 1'(READY);
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

    logic [XLEN-1:0] regs [NREGS];
    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            ready_q, ready_d;

    logic wr_ok;
    logic we0_eff;
    logic we1_eff;

    // Writes land only in READY and never on the edge that starts a new clear.
    assign wr_ok   = (state_q == S_READY) && !bus.init_req;
    assign we1_eff = wr_ok && bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));
    assign we0_eff = wr_ok && bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0))
                     && !(bus.we1 && (bus.wa1 == bus.wa0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST) begin
                    state_d   = S_READY;
                    ready_d   = 1'b1;
                    clr_cnt_d = '0;
                end
            end
            S_READY: begin
                if (bus.init_req) begin
                    state_d   = S_CLEAR;
                    ready_d   = 1'b0;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = S_CLEAR;
                ready_d   = 1'b0;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Storage carries no reset; the clear sequencer is the only initialiser.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            regs[clr_cnt_q] <= '0;
        end else begin
            if (we0_eff) regs[bus.wa0] <= bus.wd0;
            if (we1_eff) regs[bus.wa1] <= bus.wd1;
        end
    end

    assign bus.ready = ready_q;

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .active (state_q == S_READY),
            .fwd_en (!bus.init_req),
            .ra     (bus.ra[k*AW +: AW]),
            .regs   (regs),
            .we0    (bus.we0),
            .wa0    (bus.wa0),
            .wd0    (bus.wd0),
            .we1    (bus.we1),
            .wa1    (bus.wa1),
            .wd1    (bus.wd1),
            .rd_c   (bus.rd[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus against one model.
module tb_reg_file_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

    logic clk;
    logic rst;
    logic init_req;
    logic we0, we1;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic [AW-1:0]   ra0, ra1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bif_b ();
    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bif_n ();

    assign bif_b.init_req = init_req;
    assign bif_b.ra = {ra1, ra0};
    assign bif_b.we0 = we0;
    assign bif_b.wa0 = wa0;
    assign bif_b.wd0 = wd0;
    assign bif_b.we1 = we1;
    assign bif_b.wa1 = wa1;
    assign bif_b.wd1 = wd1;
    assign bif_n.init_req = init_req;
    assign bif_n.ra = {ra1, ra0};
    assign bif_n.we0 = we0;
    assign bif_n.wa0 = wa0;
    assign bif_n.wd0 = wd0;
    assign bif_n.we1 = we1;
    assign bif_n.wa1 = wa1;
    assign bif_n.wd1 = wd1;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk (clk), .rst (rst), .bus (bif_b)
    );
    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk (clk), .rst (rst), .bus (bif_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: architectural contents plus "edges left until ready".
    logic [XLEN-1:0] mem [NREGS];
    bit m_ready = 0;
    int m_left  = 32;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready = 0;
            m_left  = 32;
        end else if (!m_ready) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_ready = 1;
                for (int i = 0; i < 32; i++) mem[i] = '0;
            end
        end else if (init_req) begin
            m_ready = 0;
            m_left  = 32;
        end else begin
            if (we0 && wa0 != 0) mem[wa0] = wd0;
            if (we1 && wa1 != 0) mem[wa1] = wd1;
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (!m_ready || a == 0) return '0;
        if (byp && !init_req && we1 && wa1 == a) return wd1;
        if (byp && !init_req && we0 && wa0 == a) return wd0;
        return mem[a];
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready_byp", 32'(bif_b.ready), 32'(m_ready));
            chk("ready_nb",  32'(bif_n.ready), 32'(m_ready));
            chk("rd0_byp", bif_b.rd[31:0],  exp_rd(ra0, 1));
            chk("rd1_byp", bif_b.rd[63:32], exp_rd(ra1, 1));
            chk("rd0_nb",  bif_n.rd[31:0],  exp_rd(ra0, 0));
            chk("rd1_nb",  bif_n.rd[63:32], exp_rd(ra1, 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        we0 = 0; we1 = 0; init_req = 0;
    endtask

    task automatic wait_ready_window(input string tag);
        repeat (31) cyc();
        chk({tag, "_low_31"}, 32'(bif_b.ready), 32'd0);
        cyc();
        chk({tag, "_high_32"}, 32'(bif_b.ready), 32'd1);
    endtask

    initial begin
        rst = 1; init_req = 0; we0 = 0; we1 = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra0 = '0; ra1 = '0;
        #1 rst = 0;
        #2 cmp_en = 1;
        repeat (3) cyc();
        rst = 1;

        // 1: clear after reset, then every entry reads zero on both ports
        wait_ready_window("rst_clear");
        for (int i = 0; i < 32; i++) begin
            ra0 = AW'(i); ra1 = AW'(31 - i);
            @(negedge clk);
            chk("init_zero_p0", bif_b.rd[31:0], 32'd0);
            chk("init_zero_p1", bif_n.rd[63:32], 32'd0);
            cyc();
        end

        // 2: simple write with same-cycle forward
        we0 = 1; wa0 = 5; wd0 = 32'hDEAD_BEEF; ra0 = 5;
        @(negedge clk);
        chk("byp_same_cycle", bif_b.rd[31:0], 32'hDEAD_BEEF);
        chk("nb_same_cycle",  bif_n.rd[31:0], 32'h0);
        cyc(); idle_wr();
        @(negedge clk);
        chk("byp_next_cycle", bif_b.rd[31:0], 32'hDEAD_BEEF);
        chk("nb_next_cycle",  bif_n.rd[31:0], 32'hDEAD_BEEF);

        // 3: same-address collision, lane 1 wins
        cyc();
        we0 = 1; wa0 = 7; wd0 = 32'h1111; we1 = 1; wa1 = 7; wd1 = 32'h2222; ra0 = 7; ra1 = 7;
        @(negedge clk);
        chk("coll_byp", bif_b.rd[63:32], 32'h2222);
        cyc(); idle_wr();
        @(negedge clk);
        chk("coll_stored", bif_n.rd[31:0], 32'h2222);

        // 4: writes to entry 0 have no effect
        cyc();
        we1 = 1; wa1 = 0; wd1 = 32'hFFFF_FFFF; ra0 = 0;
        @(negedge clk);
        chk("zero_byp", bif_b.rd[31:0], 32'h0);
        cyc(); idle_wr();
        @(negedge clk);
        chk("zero_after", bif_n.rd[31:0], 32'h0);

        // 5: fill 1..31 (two lanes per cycle), then init_req with a dropped write
        for (int i = 1; i < 32; i += 2) begin
            cyc();
            we0 = 1; wa0 = AW'(i); wd0 = 32'(i);
            we1 = (i + 1 < 32); wa1 = AW'(i + 1); wd1 = 32'(i + 1);
        end
        cyc(); idle_wr();
        for (int i = 1; i < 32; i++) begin
            ra0 = AW'(i); ra1 = AW'(32 - i);
            @(negedge clk);
            chk("fill_p0", bif_b.rd[31:0], 32'(i));
            cyc();
        end
        init_req = 1; we0 = 1; wa0 = 3; wd0 = 32'd9; ra0 = 3;
        @(negedge clk);
        chk("init_edge_no_fwd", bif_b.rd[31:0], 32'd3);
        cyc();
        init_req = 0; we0 = 1; wa0 = 3; wd0 = 32'd9;
        @(negedge clk);
        chk("clear_rd_zero", bif_b.rd[31:0], 32'd0);
        repeat (30) begin
            cyc();
            wa0 = AW'($urandom_range(1, 31)); wd0 = $urandom;
        end
        cyc();
        chk("init_low_31", 32'(bif_b.ready), 32'd0);
        cyc(); idle_wr();
        chk("init_high_32", 32'(bif_b.ready), 32'd1);
        for (int i = 0; i < 32; i++) begin
            ra0 = AW'(i); ra1 = AW'(i);
            @(negedge clk);
            chk("post_clear_zero", bif_n.rd[63:32], 32'd0);
            cyc();
        end

        // 6: reset in the middle of a clear restarts it
        init_req = 1;
        cyc(); init_req = 0;
        repeat (10) cyc();
        rst = 0;
        repeat (2) cyc();
        rst = 1;
        wait_ready_window("midclr_rst");
        we0 = 1; wa0 = 4; wd0 = 32'h55; ra0 = 4;
        @(negedge clk);
        chk("nb_old_value", bif_n.rd[31:0], 32'h0);
        chk("byp_new_value", bif_b.rd[31:0], 32'h55);
        cyc(); idle_wr();
        @(negedge clk);
        chk("nb_new_value", bif_n.rd[31:0], 32'h55);

        // Mixed traffic, checked by the per-cycle compare
        for (int i = 0; i < 64; i++) begin
            cyc();
            we0 = 1'($urandom); wa0 = AW'($urandom); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = (i % 4 == 0) ? wa0 : AW'($urandom); wd1 = $urandom;
            ra0 = (i % 3 == 0) ? wa1 : AW'($urandom);
            ra1 = (i % 3 == 1) ? wa0 : AW'($urandom);
        end
        cyc(); idle_wr();
        @(negedge clk);
        @(posedge clk);
        cmp_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
